// File: rtl/l0_ctrl_pkg.sv
// Shared types and constants for the L0 activation-buffer sequencer.
package l0_ctrl_pkg;

    localparam int L0_ROW   = 8;
    localparam int L0_DEPTH = 64;
    localparam int L0_AW    = 11;
    localparam int L0_LW    = 7;

    localparam int FLUSH_CYCLES = L0_ROW + 1;

    localparam int ERR_CLAMP = 0;
    localparam int ERR_FULL  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    // rd_en register + (row-1) stagger + FIFO output stage
    function automatic int flush_len(input int row);
        return row + 1;
    endfunction

endpackage

// File: rtl/l0_ctrl.sv
// L0 activation-buffer sequencer: load from SRAM, drain to array, flush, done.
// Optional stall counter output enabled by L0_CTRL_PERF_CNT_EN.
module l0_ctrl
    import l0_ctrl_pkg::*;
#(
    parameter int ROW   = L0_ROW,
    parameter int DEPTH = L0_DEPTH,
    parameter int AW    = L0_AW,
    parameter int LW    = L0_LW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] len,
    input  logic          drain_hold,
    output logic          sram_cen,
    output logic [AW-1:0] sram_addr,
    output logic          l0_wr,
    output logic          l0_rd,
    input  logic          l0_full,
    output logic          busy,
    output logic          done,
    output logic [1:0]    err
`ifdef L0_CTRL_PERF_CNT_EN
   ,output logic [15:0]   perf_stall
`endif
);

    localparam int FLUSH_N = flush_len(ROW);
    localparam int CNT_MAX = (DEPTH > FLUSH_N) ? DEPTH : FLUSH_N;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic          wr_q, wr_d;
    logic [1:0]    err_q, err_d;

    logic          len_over;
    logic [LW-1:0] len_clamp;
    logic          cnt_zero, cnt_one;

    assign len_over  = (len > LW'(DEPTH));
    assign len_clamp = len_over ? LW'(DEPTH) : len;
    assign cnt_zero  = (cnt_q == '0);
    assign cnt_one   = (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            wr_q    <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_LOAD;
            ST_LOAD:  if (cnt_zero) state_d = ST_DRAIN;
            ST_DRAIN: if (!drain_hold && cnt_one) state_d = ST_FLUSH;
            ST_FLUSH: if (cnt_one) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sram_cen = 1'b1;
        l0_rd    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                sram_cen = cnt_zero;
                busy     = 1'b1;
            end
            ST_DRAIN: begin
                l0_rd = !drain_hold;
                busy  = 1'b1;
            end
            ST_FLUSH: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default:  ;
        endcase
    end

    assign sram_addr = addr_q;
    assign l0_wr     = wr_q;
    assign err       = err_q;

    // One down-counter serves issue, drain and flush; it is reloaded at each phase entry.
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        len_d  = len_q;
        err_d  = err_q;
        wr_d   = (state_q == ST_LOAD) && !cnt_zero;
        case (state_q)
            ST_IDLE: if (start) begin
                addr_d = base_addr;
                len_d  = len_clamp;
                cnt_d  = CW'(len_clamp);
                if (len_over) err_d[ERR_CLAMP] = 1'b1;
            end
            ST_LOAD: begin
                if (!cnt_zero) begin
                    cnt_d  = cnt_q - CW'(1);
                    addr_d = addr_q + AW'(1);
                end else begin
                    cnt_d = CW'(len_q);
                end
            end
            ST_DRAIN: if (!drain_hold) cnt_d = cnt_one ? CW'(FLUSH_N) : cnt_q - CW'(1);
            ST_FLUSH: cnt_d = cnt_q - CW'(1);
            default:  ;
        endcase
        if (wr_q && l0_full) err_d[ERR_FULL] = 1'b1;
    end

`ifdef L0_CTRL_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_IDLE && start)
            perf_d = '0;
        else if (state_q == ST_DRAIN && drain_hold && perf_q != 16'hFFFF)
            perf_d = perf_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_l0_ctrl.sv
// Self-checking bench for l0_ctrl: timeline-based reference model plus directed literals.
module tb_l0_ctrl;

    localparam int ROWN = 8;
    localparam int DEP  = 64;

    logic        clk = 1'b0;
    logic        reset, start, drain_hold, l0_full;
    logic [10:0] base_addr;
    logic [6:0]  len;
    logic        sram_cen, l0_wr, l0_rd, busy, done;
    logic [10:0] sram_addr;
    logic [1:0]  err;
`ifdef L0_CTRL_PERF_CNT_EN
    logic [15:0] perf_stall;
`endif

    l0_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
        .drain_hold(drain_hold), .sram_cen(sram_cen), .sram_addr(sram_addr),
        .l0_wr(l0_wr), .l0_rd(l0_rd), .l0_full(l0_full), .busy(busy), .done(done),
        .err(err)
`ifdef L0_CTRL_PERF_CNT_EN
       ,.perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: a job is described by its cycle offset t since the accepting edge.
    bit       m_job = 0;
    int       m_L, m_base, m_t, m_rd, m_td;
    bit [1:0] m_err = 0;
    int       m_perf = 0;
    int       cyc = 0;
    bit       started = 0;

    function automatic bit m_in_drain();
        return m_job && m_L > 0 && m_t >= m_L + 2 && m_rd < m_L;
    endfunction

    function automatic bit m_done();
        if (!m_job) return 1'b0;
        if (m_L == 0) return m_t == 1;
        return m_td != 0 && m_t == m_td + ROWN + 2;
    endfunction

    always @(posedge clk) begin
        cyc++;
        started = 1;
        if (reset) begin
            m_job = 0; m_err = 0; m_perf = 0;
        end else if (m_job) begin
            if (m_L > 0 && m_t >= 2 && m_t <= m_L + 1 && l0_full) m_err[1] = 1'b1;
            if (m_in_drain()) begin
                if (drain_hold) begin
                    if (m_perf < 65535) m_perf++;
                end else begin
                    m_rd++;
                    if (m_rd == m_L) m_td = m_t;
                end
            end
            if (m_done()) m_job = 0;
            else          m_t++;
        end else if (start) begin
            m_job = 1; m_t = 1; m_rd = 0; m_td = 0; m_base = int'(base_addr); m_perf = 0;
            if (int'(len) > DEP) begin m_L = DEP; m_err[0] = 1'b1; end
            else m_L = int'(len);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit e_cen, e_wr, e_rd, e_busy, e_done;
            e_cen = 1; e_wr = 0; e_rd = 0; e_busy = 0; e_done = 0;
            if (m_job) begin
                e_done = m_done();
                e_busy = m_L > 0 && !e_done;
                if (m_L > 0) begin
                    e_cen = !(m_t >= 1 && m_t <= m_L);
                    e_wr  = m_t >= 2 && m_t <= m_L + 1;
                    e_rd  = m_in_drain() && !drain_hold;
                end
            end
            chk("sram_cen", sram_cen, e_cen);
            if (!e_cen) chk("sram_addr", sram_addr, (m_base + m_t - 1) % 2048);
            chk("l0_wr", l0_wr, e_wr);
            chk("l0_rd", l0_rd, e_rd);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("err", err, m_err);
`ifdef L0_CTRL_PERF_CNT_EN
            chk("perf_stall", perf_stall, m_perf);
`endif
        end
    end

    // Running strobe totals; jobs take differences
    int tot_cen = 0, tot_wr = 0, tot_rd = 0;
    int aq[$];
    always @(negedge clk) begin
        if (!sram_cen) begin tot_cen++; aq.push_back(int'(sram_addr)); end
        if (l0_wr) tot_wr++;
        if (l0_rd) tot_rd++;
    end

    int r_off, r_cen, r_wr, r_rd, r_aidx;

    // Entered and left just after a rising edge with the DUT idle.
    task automatic run_job(input logic [10:0] b, input int l, input int hf, input int hl,
                           input bit rh, input bit fm, input bit pk);
        int c0, w0, d0;
        c0 = tot_cen; w0 = tot_wr; d0 = tot_rd; r_aidx = aq.size();
        base_addr = b; len = 7'(l); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        r_off = -1;
        for (int n = 1; n < 600; n++) begin
            drain_hold = rh ? ($urandom_range(2) == 0) : (n >= hf && n < hf + hl);
            l0_full    = fm ? (n == 3) : (rh ? ($urandom_range(15) == 0) : 1'b0);
            start      = pk && n >= 2 && n <= 5;
            @(negedge clk);
            if (done) begin r_off = n; break; end
            @(posedge clk); #1;
        end
        if (r_off < 0) begin
            checks++; errors++;
            $display("FAIL done_timeout got=none exp=done_pulse len=%0d", l);
        end
        @(posedge clk); #1;
        start = 1'b0; drain_hold = 1'b0; l0_full = 1'b0;
        r_cen = tot_cen - c0; r_wr = tot_wr - w0; r_rd = tot_rd - d0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; drain_hold = 1'b0; l0_full = 1'b0;
        base_addr = '0; len = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cen", sram_cen, 1); chk("rst_addr", sram_addr, 0);
        chk("rst_wr", l0_wr, 0);     chk("rst_rd", l0_rd, 0);
        chk("rst_busy", busy, 0);    chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(posedge clk); #1;

        run_job(11'h010, 4, 0, 0, 0, 0, 0);
        chk("t1_done_at", r_off, 19); chk("t1_cen", r_cen, 4);
        chk("t1_wr", r_wr, 4); chk("t1_rd", r_rd, 4); chk("t1_err", err, 0);
        chk("t1_addr0", aq[r_aidx], 11'h010); chk("t1_addr3", aq[r_aidx+3], 11'h013);

        run_job(11'h7FE, 3, 0, 0, 0, 0, 0);
        chk("t2_done_at", r_off, 17);
        chk("t2_addr0", aq[r_aidx], 11'h7FE); chk("t2_addr1", aq[r_aidx+1], 11'h7FF);
        chk("t2_addr2", aq[r_aidx+2], 11'h000);

        run_job(11'h020, 4, 7, 2, 0, 0, 0);
        chk("t3_done_at", r_off, 21); chk("t3_rd", r_rd, 4);
`ifdef L0_CTRL_PERF_CNT_EN
        chk("t3_perf", perf_stall, 2);
`endif

        run_job(11'h040, 4, 0, 0, 0, 1, 1);
        chk("t5_err", err, 2'b10); chk("t5_cen", r_cen, 4); chk("t5_done_at", r_off, 19);

        run_job(11'h050, 0, 0, 0, 0, 0, 0);
        chk("len0_done_at", r_off, 1); chk("len0_cen", r_cen, 0);
        chk("len0_wr", r_wr, 0); chk("len0_rd", r_rd, 0);

        run_job(11'h100, 100, 0, 0, 0, 0, 0);
        chk("clamp_err", err, 2'b11); chk("clamp_wr", r_wr, 64);
        chk("clamp_rd", r_rd, 64); chk("clamp_cen", r_cen, 64);
        chk("clamp_done_at", r_off, 139);

        // Reset in the middle of DRAIN (drain spans cycles 10..17 for len=8)
        base_addr = 11'h100; len = 7'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid_cen", sram_cen, 1); chk("mid_addr", sram_addr, 0);
        chk("mid_wr", l0_wr, 0);     chk("mid_rd", l0_rd, 0);
        chk("mid_busy", busy, 0);    chk("mid_err", err, 0);
        chk("mid_done", done, 0);
        repeat (3) begin @(posedge clk); @(negedge clk); chk("mid_nodone", done, 0); end
        @(posedge clk); #1;
        run_job(11'h010, 4, 0, 0, 0, 0, 0);
        chk("post_rst_done_at", r_off, 19); chk("post_rst_rd", r_rd, 4);

        for (int j = 0; j < 30; j++) begin
            int rl;
            rl = (j % 7 == 6) ? int'($urandom_range(80)) : int'($urandom_range(DEP));
            run_job(11'($urandom), rl, 0, 0, 1, 0, 0);
            chk("rnd_rd_count", r_rd, (rl > DEP) ? DEP : rl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l0_ctrl.md
Name: l0_ctrl

Overview:
- Sequencer for the L0 activation buffer.
- On a start command it:
  - streams LEN activation vectors from the activation SRAM into L0 (load phase),
  - drains them into the systolic array by asserting the L0 read strobe LEN times (drain phase),
  - waits out the L0 row-stagger pipeline (flush phase),
  - pulses done.
- Sits between the core's top-level FSM and the L0 instance plus the activation SRAM read port.

Parameters:
- ROW, 8, number of L0 row FIFOs; sets flush length.
- DEPTH, 64, L0 FIFO depth; maximum legal LEN.
- AW, 11, activation SRAM address width.
- LW, 7, width of len input (clog2(DEPTH)+1).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  command strobe; sampled only in IDLE
- base_addr  input  AW  first SRAM address of the vector block
- len  input  LW  number of vectors to load and drain
- drain_hold  input  1  downstream stall; freezes drain when high
- sram_cen  output  1  activation SRAM chip enable, active-low
- sram_addr  output  AW  activation SRAM read address
- l0_wr  output  1  L0 write strobe
- l0_rd  output  1  L0 read strobe
- l0_full  input  1  L0 o_full
- busy  output  1  high from LOAD through FLUSH
- done  output  1  one-cycle completion pulse
- err  output  2  sticky flags: [0] len clamped, [1] write while l0_full

Behaviour:
- Reset values:
  - state IDLE; sram_cen=1, sram_addr=0, l0_wr=0, l0_rd=0, busy=0, done=0, err=0.
  - All counters 0.
- Reset mid-operation: IDLE on the next edge, no done pulse. L0 shares the same reset; the controller does not flush L0 itself.
- States: IDLE, LOAD, DRAIN, FLUSH, DONE.
- IDLE:
  - On start, latch base_addr and len.
  - len>DEPTH: clamp to DEPTH, set err[0].
  - len==0: go to DONE directly, so done is high on the cycle after start.
  - Otherwise go to LOAD.
  - start while busy or in DONE is ignored.
- LOAD:
  - sram_cen=0 for exactly LEN consecutive cycles.
  - sram_addr = base+k, k=0..LEN-1, modulo 2^AW (wraps silently).
  - SRAM read latency is 1 cycle, so l0_wr is the 1-cycle-delayed copy of the read issue. l0_wr is high for LEN cycles, starting one cycle after the first sram_cen=0.
  - Go to DRAIN the cycle after the last l0_wr.
  - l0_full high while l0_wr is high: set err[1]; the write is still issued.
- DRAIN:
  - l0_rd = !drain_hold.
  - The drain counter increments on each l0_rd cycle.
  - Go to FLUSH after the LEN-th l0_rd cycle.
  - drain_hold does not affect LOAD or FLUSH.
- FLUSH: ROW+1 cycles (1 for the L0 internal rd_en register, ROW-1 for row stagger, 1 for FIFO output), then DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE. A start may be accepted on the following cycle.
- Latency without hold: start sampled at edge 0 gives:
  - sram_cen low cycles 1..LEN
  - l0_wr cycles 2..LEN+1
  - l0_rd cycles LEN+2..2LEN+1
  - done at cycle 2LEN+ROW+3
- Each drain_hold cycle during DRAIN adds one cycle.

Optional Feature:
- Macro: L0_CTRL_PERF_CNT_EN.
- When defined:
  - Adds output perf_stall (16 bits): count of DRAIN cycles with drain_hold=1, saturating at 0xFFFF.
  - Cleared on reset and on each accepted start; holds its value after done.
- When undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package l0_ctrl_pkg: state enum (IDLE, LOAD, DRAIN, FLUSH, DONE), FLUSH_CYCLES = ROW+1, err bit index constants.
- Single module. The three counters (issue, drain, flush) share one reloadable down-counter; no sub-module is warranted.

Test Plan:
- len=4, base=0x010, no hold:
  - sram_addr 0x010..0x013 on cycles 1-4
  - l0_wr cycles 2-5
  - l0_rd cycles 6-9
  - done at cycle 19, err=0
- len=3, base=0x7FE: addresses 0x7FE, 0x7FF, 0x000; done at cycle 17.
- len=4, drain_hold high for 2 cycles mid-DRAIN:
  - l0_rd gaps exactly 2 cycles; still 4 rd cycles total
  - done at cycle 21
  - perf_stall=2 when the macro is defined
- len=100: clamped to 64, err[0]=1, 64 l0_wr and 64 l0_rd pulses; len=0 gives done on cycle 1 with no strobes.
- reset asserted mid-DRAIN: next cycle all outputs at reset values, no done; a new start then runs a clean sequence.
- l0_full forced high during LOAD: err[1] set and stays set until reset; start during busy ignored (no extra SRAM reads).
